pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the five-stage pipeline (IF, ID, RR, EX, MEM/WB).
// Detects load-use, taken branches and data-memory waits, and drives
// stage stall, bubble, hold and flush controls plus EX operand forwarding.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-low reset
//   i_rr_*             RR-stage source registers and rt-use flag
//   i_ex_*             EX-stage sources, destination, write/load flags
//   i_mem_*, i_wb_*    MEM/WB destinations and write enables
//   i_dmem_busy        data memory not ready
//   i_branch_taken     branch resolved taken in EX
//   o_*_stall          hold PC, IF/ID, ID/RR registers
//   o_rrex_bubble      zero RR/EX contents
//   o_rrex_hold        RR/EX keeps its value
//   o_exmem_hold       EX/MEM keeps its value
//   o_flush_front      clear IF/ID and ID/RR
//   o_fwd_a, o_fwd_b   EX operand select: 00 regfile, 01 MEM, 10 WB
//   o_mem_timeout      sticky: memory wait reached TIMEOUT cycles
//   o_stall_count      saturating count of PC-stall cycles
//   o_state            controller state

module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  i_rr_rs,
    input  logic [4:0]  i_rr_rt,
    input  logic        i_rr_uses_rt,
    input  logic [4:0]  i_ex_rs,
    input  logic [4:0]  i_ex_rt,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_regwrite,
    input  logic        i_ex_memread,
    input  logic [4:0]  i_mem_rd,
    input  logic        i_mem_regwrite,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_wb_regwrite,
    input  logic        i_dmem_busy,
    input  logic        i_branch_taken,
    output logic        o_pc_stall,
    output logic        o_ifid_stall,
    output logic        o_idrr_stall,
    output logic        o_rrex_bubble,
    output logic        o_rrex_hold,
    output logic        o_exmem_hold,
    output logic        o_flush_front,
    output logic [1:0]  o_fwd_a,
    output logic [1:0]  o_fwd_b,
    output logic        o_mem_timeout,
    output logic [15:0] o_stall_count,
    output logic [1:0]  o_state
);

    // Wait counter is 8 bits; clamp the limit into its reachable range.
    localparam logic [7:0] TO_LIMIT =
        (TIMEOUT == 0)   ? 8'd1  :
        (TIMEOUT > 255)  ? 8'hFF :
                           8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_FLUSH    = 2'b10,
        ST_BAD      = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_inc;
    logic [15:0] r_stall_count;
    logic        r_mem_timeout;

    logic        w_rs_dep;
    logic        w_rt_dep;
    logic        w_load_use;
    logic        w_mem_stall;
    logic        w_lu_stall;
    logic        w_bubble;
    logic        w_flush;
    logic        w_front_stall;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Load in EX whose result an RR-stage instruction needs next cycle.
    assign w_rs_dep   = (i_ex_rd == i_rr_rs);
    assign w_rt_dep   = i_rr_uses_rt & (i_ex_rd == i_rr_rt);
    assign w_load_use = i_ex_memread & i_ex_regwrite &
                        (i_ex_rd != 5'd0) & (w_rs_dep | w_rt_dep);

    // Next state and control decode; everything idles while in reset.
    always_comb begin
        w_mem_stall  = 1'b0;
        w_lu_stall   = 1'b0;
        w_bubble     = 1'b0;
        w_flush      = 1'b0;
        w_next_state = ST_RUN;
        if (reset) begin
            case (r_state)
                ST_RUN: begin
                    if (i_dmem_busy) begin
                        w_mem_stall  = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end else if (i_branch_taken) begin
                        w_flush      = 1'b1;
                        w_bubble     = 1'b1;
                        w_next_state = ST_FLUSH;
                    end else if (w_load_use) begin
                        // Load leaves EX next edge: one bubble suffices.
                        w_lu_stall   = 1'b1;
                        w_bubble     = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (i_dmem_busy) begin
                        w_mem_stall  = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end
                end
                ST_FLUSH: begin
                    // Stale fetch behind the branch is killed here
                    // unless memory stalls the whole pipe first.
                    if (i_dmem_busy) begin
                        w_mem_stall  = 1'b1;
                        w_next_state = ST_MEM_WAIT;
                    end else begin
                        w_flush      = 1'b1;
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                end
            endcase
        end
    end

    assign w_front_stall = w_mem_stall | w_lu_stall;

    assign o_pc_stall    = w_front_stall;
    assign o_ifid_stall  = w_front_stall;
    assign o_idrr_stall  = w_front_stall;
    // Bubble only arises on non-memory paths, so never overlaps hold.
    assign o_rrex_bubble = w_bubble;
    assign o_rrex_hold   = w_mem_stall;
    assign o_exmem_hold  = w_mem_stall;
    assign o_flush_front = w_flush;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        // Younger result in MEM takes precedence over WB.
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            sel = 2'b01;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    assign w_fwd_a = fwd_sel(i_ex_rs, i_mem_rd, i_mem_regwrite,
                             i_wb_rd, i_wb_regwrite);
    assign w_fwd_b = fwd_sel(i_ex_rt, i_mem_rd, i_mem_regwrite,
                             i_wb_rd, i_wb_regwrite);

    assign o_fwd_a = reset ? w_fwd_a : 2'b00;
    assign o_fwd_b = reset ? w_fwd_b : 2'b00;

    assign w_wait_inc = (r_wait_cnt == 8'hFF) ? 8'hFF
                                              : r_wait_cnt + 8'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_stall_count <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Counts consecutive memory-wait cycles; any gap clears it.
            if (w_mem_stall) begin
                r_wait_cnt <= w_wait_inc;
            end else begin
                r_wait_cnt <= 8'd0;
            end
            if (w_mem_stall && (w_wait_inc >= TO_LIMIT)) begin
                r_mem_timeout <= 1'b1;
            end
            if (w_front_stall && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign o_state       = r_state;
    assign o_stall_count = r_stall_count;
    assign o_mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences and random stimulus against a behavioural model.

module tb_pipeline_hazard_ctrl;

    localparam int TO      = 255;
    localparam int M_RUN   = 0;
    localparam int M_WAIT  = 1;
    localparam int M_FLUSH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  rr_rs, rr_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        rr_uses_rt, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, dmem_busy, branch_taken;
    logic        pc_stall, ifid_stall, idrr_stall, rrex_bubble;
    logic        rrex_hold, exmem_hold, flush_front, mem_timeout;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_count;

    int n_assert = 0;
    int n_fail   = 0;

    int m_mode, m_stall, m_wait;
    bit m_to;

    pipeline_hazard_ctrl #(.TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .i_rr_rs        (rr_rs),
        .i_rr_rt        (rr_rt),
        .i_rr_uses_rt   (rr_uses_rt),
        .i_ex_rs        (ex_rs),
        .i_ex_rt        (ex_rt),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_memread   (ex_memread),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .i_dmem_busy    (dmem_busy),
        .i_branch_taken (branch_taken),
        .o_pc_stall     (pc_stall),
        .o_ifid_stall   (ifid_stall),
        .o_idrr_stall   (idrr_stall),
        .o_rrex_bubble  (rrex_bubble),
        .o_rrex_hold    (rrex_hold),
        .o_exmem_hold   (exmem_hold),
        .o_flush_front  (flush_front),
        .o_fwd_a        (fwd_a),
        .o_fwd_b        (fwd_b),
        .o_mem_timeout  (mem_timeout),
        .o_stall_count  (stall_count),
        .o_state        (state)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         pc;
        bit         bub;
        bit         hold;
        bit         flush;
        bit         mem;
        logic [1:0] fa;
        logic [1:0] fb;
        int         nxt;
    } exp_t;

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (mem_regwrite && mem_rd != 0 && mem_rd == src) return 2'b01;
        if (wb_regwrite && wb_rd != 0 && wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    // Memory wait dominates in every mode; branch and load-use only
    // matter in RUN; FLUSH just kills the stale fetch once.
    function automatic exp_t model_out();
        exp_t e;
        bit   lu;
        e.pc = 0; e.bub = 0; e.hold = 0; e.flush = 0; e.mem = 0;
        e.fa = 2'b00; e.fb = 2'b00; e.nxt = M_RUN;
        if (reset !== 1'b1) return e;
        lu = ex_memread && ex_regwrite && ex_rd != 0 &&
             (ex_rd == rr_rs || (rr_uses_rt && ex_rd == rr_rt));
        e.fa = ref_fwd(ex_rs);
        e.fb = ref_fwd(ex_rt);
        if (dmem_busy) begin
            e.mem = 1; e.pc = 1; e.hold = 1; e.nxt = M_WAIT;
        end else if (m_mode == M_RUN && branch_taken) begin
            e.flush = 1; e.bub = 1; e.nxt = M_FLUSH;
        end else if (m_mode == M_RUN && lu) begin
            e.pc = 1; e.bub = 1;
        end else if (m_mode == M_FLUSH) begin
            e.flush = 1;
        end
        return e;
    endfunction

    task automatic step(input string tag);
        exp_t e;
        @(negedge clock);
        e = model_out();
        chk({tag, ".pc_stall"},    32'(pc_stall),    32'(e.pc));
        chk({tag, ".ifid_stall"},  32'(ifid_stall),  32'(e.pc));
        chk({tag, ".idrr_stall"},  32'(idrr_stall),  32'(e.pc));
        chk({tag, ".rrex_bubble"}, 32'(rrex_bubble), 32'(e.bub));
        chk({tag, ".rrex_hold"},   32'(rrex_hold),   32'(e.hold));
        chk({tag, ".exmem_hold"},  32'(exmem_hold),  32'(e.hold));
        chk({tag, ".flush_front"}, 32'(flush_front), 32'(e.flush));
        chk({tag, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
        chk({tag, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
        chk({tag, ".state"},       32'(state),       32'(m_mode));
        chk({tag, ".stall_count"}, 32'(stall_count), 32'(m_stall));
        chk({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(m_to));
        @(posedge clock);
        if (reset !== 1'b1) begin
            m_mode = M_RUN; m_stall = 0; m_wait = 0; m_to = 0;
        end else begin
            if (e.pc && m_stall < 65535) m_stall++;
            m_wait = e.mem ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
            if (e.mem && m_wait >= TO) m_to = 1;
            m_mode = e.nxt;
        end
        #1;
    endtask

    task automatic idle();
        reset = 1'b1;
        rr_rs = '0; rr_rt = '0; rr_uses_rt = 1'b0;
        ex_rs = '0; ex_rt = '0; ex_rd = '0;
        ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = '0; mem_regwrite = 1'b0;
        wb_rd = '0; wb_regwrite = 1'b0;
        dmem_busy = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic set_load_use();
        ex_memread = 1'b1; ex_regwrite = 1'b1;
        ex_rd = 5'd5; rr_rs = 5'd5;
    endtask

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urt;
        logic [4:0] xs, xt, xd;
        logic       mrd, rw;
        logic [4:0] md;
        logic       mw;
        logic [4:0] wd;
        logic       ww;
        logic       stall;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"lu_rs",   5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5,
                    1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[1] = '{"rd_zero", 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0,
                    1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[2] = '{"lu_rt",   5'd3, 5'd9, 1'b1, 5'd0, 5'd0, 5'd9,
                    1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00};
        vecs[3] = '{"rt_nuse", 5'd3, 5'd9, 1'b0, 5'd0, 5'd0, 5'd9,
                    1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[4] = '{"no_load", 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5,
                    1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[5] = '{"no_wr",   5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5,
                    1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
        vecs[6] = '{"fwd_mem", 5'd0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd0,
                    1'b0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 2'b01, 2'b01};
        vecs[7] = '{"fwd_wb",  5'd0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd0,
                    1'b0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 2'b10, 2'b10};
        vecs[8] = '{"fwd_r0",  5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0,
                    1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[9] = '{"fwd_mix", 5'd0, 5'd0, 1'b0, 5'd6, 5'd4, 5'd0,
                    1'b0, 1'b0, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 2'b10, 2'b01};

        idle();
        reset = 1'b0;
        m_mode = M_RUN; m_stall = 0; m_wait = 0; m_to = 0;
        repeat (2) @(posedge clock);
        #1;

        // Reset forces every control output low despite busy inputs.
        dmem_busy = 1'b1; branch_taken = 1'b1; set_load_use();
        mem_rd = 5'd7; mem_regwrite = 1'b1; ex_rs = 5'd7; ex_rt = 5'd7;
        #2;
        chk("rst.pc_stall", 32'(pc_stall), 32'd0);
        chk("rst.flush", 32'(flush_front), 32'd0);
        chk("rst.fwd_a", 32'(fwd_a), 32'd0);
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.stall_count", 32'(stall_count), 32'd0);
        step("rst");
        idle();

        foreach (vecs[i]) begin
            rr_rs = vecs[i].rs; rr_rt = vecs[i].rt;
            rr_uses_rt = vecs[i].urt;
            ex_rs = vecs[i].xs; ex_rt = vecs[i].xt; ex_rd = vecs[i].xd;
            ex_memread = vecs[i].mrd; ex_regwrite = vecs[i].rw;
            mem_rd = vecs[i].md; mem_regwrite = vecs[i].mw;
            wb_rd = vecs[i].wd; wb_regwrite = vecs[i].ww;
            #2;
            chk({vecs[i].name, ".stall"}, 32'(pc_stall), 32'(vecs[i].stall));
            chk({vecs[i].name, ".bubble"}, 32'(rrex_bubble),
                32'(vecs[i].stall));
            chk({vecs[i].name, ".fa"}, 32'(fwd_a), 32'(vecs[i].fa));
            chk({vecs[i].name, ".fb"}, 32'(fwd_b), 32'(vecs[i].fb));
            step(vecs[i].name);
        end

        // Single load-use bubble, counter 0 -> 1.
        idle(); reset = 1'b0; step("rst2"); idle();
        set_load_use();
        #2;
        chk("lu.pc_stall", 32'(pc_stall), 32'd1);
        chk("lu.bubble", 32'(rrex_bubble), 32'd1);
        step("lu");
        idle();
        #2;
        chk("lu.after_count", 32'(stall_count), 32'd1);
        chk("lu.after_state", 32'(state), 32'd0);
        chk("lu.after_stall", 32'(pc_stall), 32'd0);
        step("lu2");

        // Taken branch: flush+bubble, then flush in FLUSH, then idle.
        branch_taken = 1'b1;
        #2;
        chk("br.flush", 32'(flush_front), 32'd1);
        chk("br.bubble", 32'(rrex_bubble), 32'd1);
        chk("br.pc_stall", 32'(pc_stall), 32'd0);
        step("br1");
        branch_taken = 1'b0;
        #2;
        chk("br.state2", 32'(state), 32'd2);
        chk("br.flush2", 32'(flush_front), 32'd1);
        chk("br.bubble2", 32'(rrex_bubble), 32'd0);
        step("br2");
        #2;
        chk("br.state3", 32'(state), 32'd0);
        chk("br.flush3", 32'(flush_front), 32'd0);
        step("br3");

        // Memory wait beats branch and load-use for three cycles.
        reset = 1'b0; step("rst3"); idle();
        dmem_busy = 1'b1; branch_taken = 1'b1; set_load_use();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("mw.pc_stall", 32'(pc_stall), 32'd1);
            chk("mw.rrex_hold", 32'(rrex_hold), 32'd1);
            chk("mw.exmem_hold", 32'(exmem_hold), 32'd1);
            chk("mw.bubble", 32'(rrex_bubble), 32'd0);
            chk("mw.flush", 32'(flush_front), 32'd0);
            step("mw");
        end
        idle();
        #2;
        chk("mw.end_state", 32'(state), 32'd1);
        chk("mw.end_stall", 32'(pc_stall), 32'd0);
        chk("mw.end_count", 32'(stall_count), 32'd3);
        step("mw_end");
        #2;
        chk("mw.run_state", 32'(state), 32'd0);
        step("mw_run");

        // Reset in the middle of a wait abandons it.
        dmem_busy = 1'b1;
        step("rw1"); step("rw2");
        reset = 1'b0;
        #2;
        chk("rw.state", 32'(state), 32'd1);
        chk("rw.pc_stall", 32'(pc_stall), 32'd0);
        chk("rw.hold", 32'(rrex_hold), 32'd0);
        step("rw_rst");
        idle();
        #2;
        chk("rw.after_state", 32'(state), 32'd0);
        step("rw_after");

        // Timeout sets on the 255th wait cycle and stays until reset.
        dmem_busy = 1'b1;
        repeat (TO - 1) step("to");
        #2;
        chk("to.before", 32'(mem_timeout), 32'd0);
        step("to_last");
        #2;
        chk("to.set", 32'(mem_timeout), 32'd1);
        dmem_busy = 1'b0;
        repeat (5) step("to_hold");
        #2;
        chk("to.sticky", 32'(mem_timeout), 32'd1);
        reset = 1'b0;
        step("to_rst");
        reset = 1'b1;
        #2;
        chk("to.cleared", 32'(mem_timeout), 32'd0);
        step("to_clr");

        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 49) != 0);
            rr_rs        = 5'($urandom_range(0, 3));
            rr_rt        = 5'($urandom_range(0, 3));
            rr_uses_rt   = 1'($urandom_range(0, 1));
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            mem_rd       = 5'($urandom_range(0, 3));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_rd        = 5'($urandom_range(0, 3));
            wb_regwrite  = 1'($urandom_range(0, 1));
            dmem_busy    = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 5) == 0);
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
